// File: rtl/pipeline_pkg.sv
// Shared definitions for the fetch / IF-ID slice.
//   XLEN          : datapath width
//   NOP_INST_DEF  : default bubble encoding (addi x0,x0,0)
//   fetch_state_e : fetch FSM state encoding
//   align_word()  : forces a byte address down to a word boundary
package pipeline_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DROP  = 2'd2
  } fetch_state_e;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register.
//   clk, rst      : clock, asynchronous active-high reset
//   flush_i       : invalidate contents (inst becomes NOP, pc kept); wins over load
//   load_i        : capture pc_i / inst_i as a live instruction
//   pc_i, inst_i  : incoming fetch
//   pc_o, inst_o, valid_o : register contents
// With neither flush_i nor load_i the register holds.
module ifid_reg
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] inst_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] inst_o,
  output logic            valid_o
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic            valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (flush_i) begin
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end else if (load_i) begin
      pc_d    = pc_i;
      inst_d  = inst_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = pc_q;
  assign inst_o  = inst_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch / redirect unit: owns the PC, the instruction-memory request handshake and
// the IF/ID register, and applies redirect, flush and load-use stall requests.
//   CLK, RST                : clock, asynchronous active-high reset
//   Hazard_Sig, Updated_PC  : redirect request and target
//   FLUSH_IFID, STALL       : IF/ID invalidate, load-use hold
//   I_MEM_REQ/ADDR/RDY/DI   : instruction memory handshake
//   IFID_PC/INST/VALID      : IF/ID register to the decode stage
//   REDIRECT_BUSY           : draining a stale in-flight fetch
//   MISALIGN_ERR            : sticky flag, a redirect target was not word aligned
module fetch_redirect_unit
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Hazard_Sig,
  input  logic [XLEN-1:0] Updated_PC,
  input  logic            FLUSH_IFID,
  input  logic            STALL,
  output logic            I_MEM_REQ,
  output logic [XLEN-1:0] I_MEM_ADDR,
  input  logic            I_MEM_RDY,
  input  logic [XLEN-1:0] I_MEM_DI,
  output logic [XLEN-1:0] IFID_PC,
  output logic [XLEN-1:0] IFID_INST,
  output logic            IFID_VALID,
  output logic            REDIRECT_BUSY,
  output logic            MISALIGN_ERR
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] redirect_tgt;
  logic            ifid_load;
  logic            ifid_flush;

  assign redirect_tgt = align_word(Updated_PC);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    mis_d      = mis_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;

    if (Hazard_Sig && (state_q != ST_IDLE) && (Updated_PC[1:0] != 2'b00))
      mis_d = 1'b1;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;

      ST_FETCH: begin
        if (Hazard_Sig) begin
          ifid_flush = 1'b1;
          if (I_MEM_RDY) begin
            pc_d = redirect_tgt;
          end else begin
            // Address must stay put until the outstanding request completes.
            pend_d  = redirect_tgt;
            state_d = ST_DROP;
          end
        end else if (FLUSH_IFID) begin
          // Any response this cycle is dropped and the same PC refetched.
          ifid_flush = 1'b1;
        end else if (STALL) begin
          ifid_flush = 1'b0;
        end else if (I_MEM_RDY) begin
          ifid_load = 1'b1;
          pc_d      = pc_q + 32'd4;
        end else begin
          ifid_flush = 1'b1;
        end
      end

      ST_DROP: begin
        ifid_flush = !(STALL && !FLUSH_IFID && !Hazard_Sig);
        if (Hazard_Sig) begin
          if (I_MEM_RDY) begin
            pc_d    = redirect_tgt;
            state_d = ST_FETCH;
          end else begin
            pend_d = redirect_tgt;
          end
        end else if (I_MEM_RDY) begin
          pc_d    = pend_q;
          state_d = ST_FETCH;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      mis_q   <= mis_d;
    end
  end

  ifid_reg #(.NOP_INST(NOP_INST)) u_ifid (
    .clk     (CLK),
    .rst     (RST),
    .flush_i (ifid_flush),
    .load_i  (ifid_load),
    .pc_i    (pc_q),
    .inst_i  (I_MEM_DI),
    .pc_o    (IFID_PC),
    .inst_o  (IFID_INST),
    .valid_o (IFID_VALID)
  );

  assign I_MEM_REQ     = (state_q != ST_IDLE);
  assign I_MEM_ADDR    = pc_q;
  assign REDIRECT_BUSY = (state_q == ST_DROP);
  assign MISALIGN_ERR  = mis_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
module tb_fetch_redirect_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] IA = 32'hA000_0001, IB = 32'hB000_0002, IC = 32'hC000_0003;
  localparam logic [31:0] ID = 32'hD000_0004, IE = 32'hE000_0005, IF_ = 32'hF000_0006;
  localparam logic [31:0] IG = 32'h1000_0007, IH = 32'h2000_0008, II = 32'h3000_0009;
  localparam logic [31:0] IJ = 32'h4000_000A, IK = 32'h5000_000B, IL = 32'h6000_000C;
  localparam logic [31:0] IM = 32'h7000_000D;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Hazard_Sig;
  logic [31:0] Updated_PC;
  logic        FLUSH_IFID;
  logic        STALL;
  logic        I_MEM_REQ;
  logic [31:0] I_MEM_ADDR;
  logic        I_MEM_RDY;
  logic [31:0] I_MEM_DI;
  logic [31:0] IFID_PC;
  logic [31:0] IFID_INST;
  logic        IFID_VALID;
  logic        REDIRECT_BUSY;
  logic        MISALIGN_ERR;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  fetch_redirect_unit dut (
    .CLK           (CLK),
    .RST           (RST),
    .Hazard_Sig    (Hazard_Sig),
    .Updated_PC    (Updated_PC),
    .FLUSH_IFID    (FLUSH_IFID),
    .STALL         (STALL),
    .I_MEM_REQ     (I_MEM_REQ),
    .I_MEM_ADDR    (I_MEM_ADDR),
    .I_MEM_RDY     (I_MEM_RDY),
    .I_MEM_DI      (I_MEM_DI),
    .IFID_PC       (IFID_PC),
    .IFID_INST     (IFID_INST),
    .IFID_VALID    (IFID_VALID),
    .REDIRECT_BUSY (REDIRECT_BUSY),
    .MISALIGN_ERR  (MISALIGN_ERR)
  );

  typedef struct {
    logic        hz;
    logic [31:0] upc;
    logic        fl;
    logic        st;
    logic        rdy;
    logic [31:0] di;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_valid;
    logic        e_busy;
    logic        e_mis;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(logic hz, logic [31:0] upc, logic fl, logic st, logic rdy,
                              logic [31:0] di, logic [31:0] e_addr, logic [31:0] e_pc,
                              logic [31:0] e_inst, logic e_valid, logic e_busy, logic e_mis);
    vec_t v;
    v.hz = hz; v.upc = upc; v.fl = fl; v.st = st; v.rdy = rdy; v.di = di;
    v.e_addr = e_addr; v.e_pc = e_pc; v.e_inst = e_inst;
    v.e_valid = e_valid; v.e_busy = e_busy; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic hz, input logic [31:0] upc, input logic fl,
                       input logic st, input logic rdy, input logic [31:0] di);
    Hazard_Sig = hz; Updated_PC = upc; FLUSH_IFID = fl; STALL = st;
    I_MEM_RDY = rdy; I_MEM_DI = di;
  endtask

  task automatic check_all(input string tag, input logic req, input logic [31:0] addr,
                           input logic [31:0] pc, input logic [31:0] inst, input logic valid,
                           input logic busy, input logic mis);
    check({tag, ".req"},   {31'd0, I_MEM_REQ}, {31'd0, req});
    check({tag, ".addr"},  I_MEM_ADDR, addr);
    check({tag, ".pc"},    IFID_PC, pc);
    check({tag, ".inst"},  IFID_INST, inst);
    check({tag, ".valid"}, {31'd0, IFID_VALID}, {31'd0, valid});
    check({tag, ".busy"},  {31'd0, REDIRECT_BUSY}, {31'd0, busy});
    check({tag, ".mis"},   {31'd0, MISALIGN_ERR}, {31'd0, mis});
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    //                hz  upc            fl st rdy di    addr           ifid_pc        inst vld bsy mis
    vecs[0]  = mk(0, 32'h0,        0, 0, 1, IA,  32'h4,        32'h0,        IA,  1, 0, 0);
    vecs[1]  = mk(0, 32'h0,        0, 0, 1, IB,  32'h8,        32'h4,        IB,  1, 0, 0);
    vecs[2]  = mk(0, 32'h0,        0, 0, 1, IC,  32'hC,        32'h8,        IC,  1, 0, 0);
    vecs[3]  = mk(1, 32'h40,       0, 0, 1, ID,  32'h40,       32'h8,        NOP, 0, 0, 0);
    vecs[4]  = mk(0, 32'h0,        0, 0, 1, IE,  32'h44,       32'h40,       IE,  1, 0, 0);
    vecs[5]  = mk(0, 32'h0,        0, 0, 0, IF_, 32'h44,       32'h40,       NOP, 0, 0, 0);
    vecs[6]  = mk(1, 32'h80,       0, 0, 0, IF_, 32'h44,       32'h40,       NOP, 0, 1, 0);
    vecs[7]  = mk(0, 32'h0,        0, 0, 0, IF_, 32'h44,       32'h40,       NOP, 0, 1, 0);
    vecs[8]  = mk(1, 32'hC0,       0, 0, 0, IF_, 32'h44,       32'h40,       NOP, 0, 1, 0);
    vecs[9]  = mk(0, 32'h0,        0, 0, 1, IF_, 32'hC0,       32'h40,       NOP, 0, 0, 0);
    vecs[10] = mk(0, 32'h0,        0, 0, 1, IG,  32'hC4,       32'hC0,       IG,  1, 0, 0);
    vecs[11] = mk(0, 32'h0,        0, 1, 1, IH,  32'hC4,       32'hC0,       IG,  1, 0, 0);
    vecs[12] = mk(0, 32'h0,        0, 1, 1, IH,  32'hC4,       32'hC0,       IG,  1, 0, 0);
    vecs[13] = mk(0, 32'h0,        0, 1, 1, IH,  32'hC4,       32'hC0,       IG,  1, 0, 0);
    vecs[14] = mk(0, 32'h0,        0, 0, 1, II,  32'hC8,       32'hC4,       II,  1, 0, 0);
    vecs[15] = mk(0, 32'h0,        1, 0, 1, IJ,  32'hC8,       32'hC4,       NOP, 0, 0, 0);
    vecs[16] = mk(0, 32'h0,        1, 1, 1, IJ,  32'hC8,       32'hC4,       NOP, 0, 0, 0);
    vecs[17] = mk(0, 32'h0,        0, 0, 1, IK,  32'hCC,       32'hC8,       IK,  1, 0, 0);
    vecs[18] = mk(1, 32'h102,      0, 0, 1, IJ,  32'h100,      32'hC8,       NOP, 0, 0, 1);
    vecs[19] = mk(0, 32'h0,        0, 0, 1, IL,  32'h104,      32'h100,      IL,  1, 0, 1);
    vecs[20] = mk(1, 32'h200,      0, 0, 0, IJ,  32'h104,      32'h100,      NOP, 0, 1, 1);
    vecs[21] = mk(1, 32'h300,      0, 0, 1, IJ,  32'h300,      32'h100,      NOP, 0, 0, 1);
    vecs[22] = mk(1, 32'h10,       1, 1, 1, IJ,  32'h10,       32'h100,      NOP, 0, 0, 1);
    vecs[23] = mk(1, 32'hFFFF_FFFC,0, 0, 1, IJ,  32'hFFFF_FFFC,32'h100,      NOP, 0, 0, 1);

    drive(0, 32'h0, 0, 0, 0, 32'h0);
    RST = 1'b1;
    #2;
    check_all("reset", 0, 32'h0, 32'h0, NOP, 0, 0, 0);
    step();
    check_all("reset_hold", 0, 32'h0, 32'h0, NOP, 0, 0, 0);
    RST = 1'b0;
    step();
    check_all("idle_to_fetch", 1, 32'h0, 32'h0, NOP, 0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].hz, vecs[i].upc, vecs[i].fl, vecs[i].st, vecs[i].rdy, vecs[i].di);
      step();
      check_all($sformatf("vec%0d", i), 1, vecs[i].e_addr, vecs[i].e_pc, vecs[i].e_inst,
                vecs[i].e_valid, vecs[i].e_busy, vecs[i].e_mis);
    end

    // PC increment wraps from the top of the address space.
    drive(0, 32'h0, 0, 0, 1, IM);
    step();
    check_all("wrap", 1, 32'h0, 32'hFFFF_FFFC, IM, 1, 0, 1);

    // Enter DROP, then reset asynchronously between edges.
    drive(1, 32'h500, 0, 0, 0, 32'h0);
    step();
    check_all("drop_before_rst", 1, 32'h0, 32'hFFFF_FFFC, NOP, 0, 1, 1);
    drive(0, 32'h0, 0, 0, 0, 32'h0);
    #2;
    RST = 1'b1;
    #1;
    check_all("async_rst", 0, 32'h0, 32'h0, NOP, 0, 0, 0);
    step();
    RST = 1'b0;
    step();
    check_all("refetch", 1, 32'h0, 32'h0, NOP, 0, 0, 0);
    drive(0, 32'h0, 0, 0, 1, IA);
    step();
    check_all("refetch_cap", 1, 32'h4, 32'h0, IA, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
